branch_cmp: RTL and testbench



---
 rtl/branch_cmp.sv | 138 +++++++++++++
 tb/tb_branch_cmp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp.sv
// Branch compare unit: one-cycle registered compare flags and taken result,
// plus saturating counters of accepted requests and taken branches.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   a/b/op carry a compare request this cycle
//   stall      hold all outputs and counters
//   flush      drop the current request, clear the result flags
//   op         compare mode (BEQ BNE BLEZ BGTZ BLTZ BGEZ SLT SLTU)
//   a, b       operands (b unused by the zero-compare modes)
//   out_valid  registered request-valid
//   taken      registered taken result for op
//   eq, lt_s, lt_u  registered a==b, signed a<b, unsigned a<b
//   taken_cnt  saturating count of accepted taken requests
//   total_cnt  saturating count of accepted requests
module branch_cmp #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             taken,
  output logic             eq,
  output logic             lt_s,
  output logic             lt_u,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             r_valid;
  logic             r_taken;
  logic             r_eq;
  logic             r_lt_s;
  logic             r_lt_u;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_total_cnt;

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;
  logic w_neg;
  logic w_zero;
  logic w_taken;
  logic w_accept;

  // Signed compare via $signed: the MSB is the sign and there is
  // no subtract, so no overflow for extreme operand pairs.
  assign w_eq   = (a == b);
  assign w_lt_s = ($signed(a) < $signed(b));
  assign w_lt_u = (a < b);
  assign w_neg  = a[WIDTH-1];
  assign w_zero = (a == '0);

  always_comb begin
    w_taken = 1'b0;
    case (op)
      OP_BEQ:  w_taken = w_eq;
      OP_BNE:  w_taken = !w_eq;
      OP_BLEZ: w_taken = w_neg || w_zero;
      OP_BGTZ: w_taken = !w_neg && !w_zero;
      OP_BLTZ: w_taken = w_neg;
      OP_BGEZ: w_taken = !w_neg;
      OP_SLT:  w_taken = w_lt_s;
      OP_SLTU: w_taken = w_lt_u;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_accept = in_valid && !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_taken     <= 1'b0;
      r_eq        <= 1'b0;
      r_lt_s      <= 1'b0;
      r_lt_u      <= 1'b0;
      r_taken_cnt <= '0;
      r_total_cnt <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_eq    <= 1'b0;
      r_lt_s  <= 1'b0;
      r_lt_u  <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_taken <= w_taken;
        r_eq    <= w_eq;
        r_lt_s  <= w_lt_s;
        r_lt_u  <= w_lt_u;
      end else begin
        r_taken <= 1'b0;
        r_eq    <= 1'b0;
        r_lt_s  <= 1'b0;
        r_lt_u  <= 1'b0;
      end
    end
    // Counters saturate independently; gated by in_valid so
    // idle-cycle garbage on a/b/op cannot reach them.
    if (!reset && w_accept) begin
      if (r_total_cnt != CNT_MAX)
        r_total_cnt <= r_total_cnt + CNT_ONE;
      if (w_taken && r_taken_cnt != CNT_MAX)
        r_taken_cnt <= r_taken_cnt + CNT_ONE;
    end
  end

  assign out_valid = r_valid;
  assign taken     = r_taken;
  assign eq        = r_eq;
  assign lt_s      = r_lt_s;
  assign lt_u      = r_lt_u;
  assign taken_cnt = r_taken_cnt;
  assign total_cnt = r_total_cnt;

endmodule

// File: tb/tb_branch_cmp.sv
// Directed testbench for branch_cmp: default instance plus a CNT_W=2
// instance sharing the same stimulus for saturation checks.
module tb_branch_cmp;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;

  logic        out_valid, taken, eq, lt_s, lt_u;
  logic [15:0] taken_cnt, total_cnt;
  logic        out_valid2, taken2, eq2, lt_s2, lt_u2;
  logic [1:0]  taken_cnt2, total_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_cmp #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .stall(stall), .flush(flush), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .taken(taken), .eq(eq),
    .lt_s(lt_s), .lt_u(lt_u),
    .taken_cnt(taken_cnt), .total_cnt(total_cnt)
  );

  branch_cmp #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .stall(stall), .flush(flush), .op(op), .a(a), .b(b),
    .out_valid(out_valid2), .taken(taken2), .eq(eq2),
    .lt_s(lt_s2), .lt_u(lt_u2),
    .taken_cnt(taken_cnt2), .total_cnt(total_cnt2)
  );

  localparam logic [2:0] BEQ  = 3'd0;
  localparam logic [2:0] BNE  = 3'd1;
  localparam logic [2:0] BLEZ = 3'd2;
  localparam logic [2:0] BGTZ = 3'd3;
  localparam logic [2:0] BLTZ = 3'd4;
  localparam logic [2:0] BGEZ = 3'd5;
  localparam logic [2:0] SLT  = 3'd6;
  localparam logic [2:0] SLTU = 3'd7;

  // flags packed as {out_valid, taken, eq, lt_s, lt_u}
  logic [4:0] got_f;
  assign got_f = {out_valid, taken, eq, lt_s, lt_u};

  task automatic drive(input logic v, input logic [2:0] o,
                       input logic [31:0] aa, input logic [31:0] bb);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, BEQ, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    checks++;
    if (got_f !== 5'b0 || total_cnt !== 16'd0 || taken_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: flags=%b tot=%0d tk=%0d want 00000 0 0",
               got_f, total_cnt, taken_cnt);
    end
    checks++;
    if (out_valid2 !== 1'b0 || total_cnt2 !== 2'd0 || taken_cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_w2: ov=%b tot=%0d tk=%0d want 0 0 0",
               out_valid2, total_cnt2, taken_cnt2);
    end
  endtask

  task automatic test_beq_ones();
    drive(1'b1, BEQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    checks++;
    if (got_f !== 5'b11100 || total_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
      errors++;
      $display("FAIL beq_ones: flags=%b tot=%0d tk=%0d want 11100 1 1",
               got_f, total_cnt, taken_cnt);
    end
  endtask

  task automatic test_slt();
    drive(1'b1, SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    checks++;
    if (got_f !== 5'b11010 || total_cnt !== 16'd2 || taken_cnt !== 16'd2) begin
      errors++;
      $display("FAIL slt: flags=%b tot=%0d tk=%0d want 11010 2 2",
               got_f, total_cnt, taken_cnt);
    end
    drive(1'b1, SLTU, 32'hFFFF_FFFF, 32'd1);
    step();
    checks++;
    if (got_f !== 5'b10010 || total_cnt !== 16'd3 || taken_cnt !== 16'd2) begin
      errors++;
      $display("FAIL sltu: flags=%b tot=%0d tk=%0d want 10010 3 2",
               got_f, total_cnt, taken_cnt);
    end
  endtask

  task automatic test_zero_cmp();
    logic [2:0]  ops [6] = '{BGTZ, BGTZ, BLEZ, BGEZ, BLTZ, BNE};
    logic [31:0] as  [6] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000,
                             32'h0, 32'h8000_0000, 32'd5};
    logic [31:0] bs  [6] = '{32'h0, 32'h0, 32'h0,
                             32'h1, 32'h7FFF_FFFF, 32'd5};
    // expected {out_valid, taken, eq, lt_s, lt_u}
    logic [4:0]  ef  [6] = '{5'b10100, 5'b11000, 5'b11010,
                             5'b11011, 5'b11010, 5'b10100};
    logic [15:0] et  [6] = '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    logic [15:0] ek  [6] = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd6};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      step();
      checks++;
      if (got_f !== ef[i] || total_cnt !== et[i] || taken_cnt !== ek[i]) begin
        errors++;
        $display("FAIL zero_cmp[%0d]: flags=%b tot=%0d tk=%0d want %b %0d %0d",
                 i, got_f, total_cnt, taken_cnt, ef[i], et[i], ek[i]);
      end
    end
  endtask

  task automatic test_idle();
    drive(1'b0, 3'bxxx, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    step();
    checks++;
    if (got_f !== 5'b0 || total_cnt !== 16'd9 || taken_cnt !== 16'd6) begin
      errors++;
      $display("FAIL idle: flags=%b tot=%0d tk=%0d want 00000 9 6",
               got_f, total_cnt, taken_cnt);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, BEQ, 32'd3, 32'd3);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SLT, 32'(i), 32'(i + 7));
      step();
      checks++;
      if (got_f !== 5'b11100 || total_cnt !== 16'd10 || taken_cnt !== 16'd7) begin
        errors++;
        $display("FAIL stall[%0d]: flags=%b tot=%0d tk=%0d want 11100 10 7",
                 i, got_f, total_cnt, taken_cnt);
      end
    end
    flush = 1'b1;
    step();
    checks++;
    if (got_f !== 5'b0 || total_cnt !== 16'd10 || taken_cnt !== 16'd7) begin
      errors++;
      $display("FAIL flush_stall: flags=%b tot=%0d tk=%0d want 00000 10 7",
               got_f, total_cnt, taken_cnt);
    end
    stall = 1'b0;
    drive(1'b1, BEQ, 32'd1, 32'd1);
    step();
    checks++;
    if (got_f !== 5'b0 || total_cnt !== 16'd10 || taken_cnt !== 16'd7) begin
      errors++;
      $display("FAIL flush: flags=%b tot=%0d tk=%0d want 00000 10 7",
               got_f, total_cnt, taken_cnt);
    end
    flush = 1'b0;
    step();
    checks++;
    if (got_f !== 5'b11100 || total_cnt !== 16'd11 || taken_cnt !== 16'd8) begin
      errors++;
      $display("FAIL after_flush: flags=%b tot=%0d tk=%0d want 11100 11 8",
               got_f, total_cnt, taken_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, BEQ, 32'(i * 3), 32'(i * 3));
      step();
      exp2 = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (total_cnt2 !== exp2 || taken_cnt2 !== exp2) begin
        errors++;
        $display("FAIL sat[%0d]: tot=%0d tk=%0d want %0d %0d",
                 i, total_cnt2, taken_cnt2, exp2, exp2);
      end
    end
    drive(1'b1, BNE, 32'd9, 32'd9);
    step();
    checks++;
    if (total_cnt2 !== 2'd3 || taken_cnt2 !== 2'd3 ||
        out_valid2 !== 1'b1 || taken2 !== 1'b0) begin
      errors++;
      $display("FAIL sat_bne: tot=%0d tk=%0d ov=%b t=%b want 3 3 1 0",
               total_cnt2, taken_cnt2, out_valid2, taken2);
    end
    checks++;
    if (total_cnt !== 16'd6 || taken_cnt !== 16'd5) begin
      errors++;
      $display("FAIL nosat_w16: tot=%0d tk=%0d want 6 5",
               total_cnt, taken_cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, BEQ, 32'd1, 32'd1);
    step();
    drive(1'b1, SLT, 32'd1, 32'd2);
    step();
    reset = 1'b1;
    stall = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if (got_f !== 5'b0 || total_cnt !== 16'd0 || taken_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b tot=%0d tk=%0d want 00000 0 0",
               got_f, total_cnt, taken_cnt);
    end
    drive(1'b1, BEQ, 32'hA5A5_0000, 32'hA5A5_0000);
    step();
    checks++;
    if (got_f !== 5'b11100 || total_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
      errors++;
      $display("FAIL post_reset: flags=%b tot=%0d tk=%0d want 11100 1 1",
               got_f, total_cnt, taken_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, BEQ, 32'd0, 32'd0);
    test_reset();
    test_beq_ones();
    test_slt();
    test_zero_cmp();
    test_idle();
    test_stall_flush();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
